// File: rtl/alu_sequencer.sv
// Hardwired fetch/execute sequencer for the 32-bit datapath's register-format ALU instructions.
// Optional single-step gating of T0 is enabled by defining ALU_SEQ_STEP_EN.
module alu_sequencer #(
  parameter int CNT_W      = 16,
  parameter int T1_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mem_ready,
`ifdef ALU_SEQ_STEP_EN
  input  logic             step,
`endif
  input  logic [31:0]      ir,
  output logic             Gra,
  output logic             Grb,
  output logic             Grc,
  output logic             Rin,
  output logic             Rout,
  output logic             PCout,
  output logic             IncPC,
  output logic             MARin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             LOin,
  output logic             HIin,
  output logic [12:0]      alu_sel,
  output logic             busy,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  localparam int TW = (T1_TIMEOUT > 1) ? $clog2(T1_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] WAIT_LAST = (T1_TIMEOUT > 0) ? TW'(T1_TIMEOUT - 1) : '0;

  state_t        state;
  logic [4:0]    op_reg;
  logic [TW-1:0] wait_cnt;

  logic [4:0]  cur_op;
  logic        bin_op, md_op, un_op, halt_op;
  logic [12:0] alu_code;
  logic        t0_go;
  logic        unused_ir;

  assign unused_ir = ^ir[26:0];

  // The opcode lives in IR during T3 only; later execute cycles use the captured copy.
  assign cur_op = (state == S_T3) ? ir[31:27] : op_reg;

`ifdef ALU_SEQ_STEP_EN
  assign t0_go = (state == S_T0) && step;
`else
  assign t0_go = (state == S_T0);
`endif

  always_comb begin
    bin_op   = 1'b0;
    md_op    = 1'b0;
    un_op    = 1'b0;
    halt_op  = 1'b0;
    alu_code = '0;
    case (cur_op)
      5'b00011: begin bin_op = 1'b1; alu_code = 13'h0400; end  // ADD
      5'b00100: begin bin_op = 1'b1; alu_code = 13'h0200; end  // SUB
      5'b00101: begin bin_op = 1'b1; alu_code = 13'h1000; end  // AND
      5'b00110: begin bin_op = 1'b1; alu_code = 13'h0800; end  // OR
      5'b00111: begin bin_op = 1'b1; alu_code = 13'h0008; end  // ROR
      5'b01000: begin bin_op = 1'b1; alu_code = 13'h0004; end  // ROL
      5'b01001: begin bin_op = 1'b1; alu_code = 13'h0040; end  // SHR
      5'b01010: begin bin_op = 1'b1; alu_code = 13'h0020; end  // SHRA
      5'b01011: begin bin_op = 1'b1; alu_code = 13'h0010; end  // SHL
      5'b01111: begin md_op  = 1'b1; alu_code = 13'h0100; end  // MUL
      5'b10000: begin md_op  = 1'b1; alu_code = 13'h0080; end  // DIV
      5'b10001: begin un_op  = 1'b1; alu_code = 13'h0002; end  // NEG
      5'b10010: begin un_op  = 1'b1; alu_code = 13'h0001; end  // NOT
      5'b11011: halt_op = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      op_reg   <= '0;
      wait_cnt <= '0;
      fault    <= 2'b00;
      retired  <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_T0;
        S_T0: begin
          if (t0_go) begin
            state    <= S_T1;
            wait_cnt <= '0;
          end
        end
        S_T1: begin
          if (mem_ready) begin
            state <= S_T2;
          end else if ((T1_TIMEOUT > 0) && (wait_cnt == WAIT_LAST)) begin
            fault <= 2'b10;
            state <= S_HALT;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        S_T2: state <= S_T3;
        S_T3: begin
          op_reg <= ir[31:27];
          if (bin_op || md_op || un_op) begin
            state <= S_T4;
          end else if (halt_op) begin
            retired <= retired + CNT_W'(1);
            state   <= S_HALT;
          end else begin
            fault <= 2'b01;
            state <= S_HALT;
          end
        end
        S_T4: begin
          if (un_op) begin
            retired <= retired + CNT_W'(1);
            state   <= S_T0;
          end else begin
            state <= S_T5;
          end
        end
        S_T5: begin
          if (md_op) begin
            state <= S_T6;
          end else begin
            retired <= retired + CNT_W'(1);
            state   <= S_T0;
          end
        end
        S_T6: begin
          retired <= retired + CNT_W'(1);
          state   <= S_T0;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the registered state so reset clears them immediately.
  always_comb begin
    Gra      = 1'b0;
    Grb      = 1'b0;
    Grc      = 1'b0;
    Rin      = 1'b0;
    Rout     = 1'b0;
    PCout    = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    alu_sel  = '0;
    case (state)
      S_T0: begin
        PCout = t0_go;
        MARin = t0_go;
        IncPC = t0_go;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      S_T3: begin
        if (bin_op) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (md_op) begin
          Gra  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (un_op) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Zin     = 1'b1;
          alu_sel = alu_code;
        end
      end
      S_T4: begin
        if (un_op) begin
          Zlowout = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
        end else begin
          Grc     = bin_op;
          Grb     = md_op;
          Rout    = 1'b1;
          Zin     = 1'b1;
          alu_sel = alu_code;
        end
      end
      S_T5: begin
        Zlowout = 1'b1;
        Gra     = bin_op;
        Rin     = bin_op;
        LOin    = md_op;
      end
      S_T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy   = (state != S_IDLE) && (state != S_HALT);
  assign halted = (state == S_HALT);

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: expected per-cycle strobes/status are queued per
// instruction and compared cycle by cycle against the DUT outputs.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mem_ready;
  logic [31:0] ir;
`ifdef ALU_SEQ_STEP_EN
  logic        step = 1'b1;
`endif
  logic Gra, Grb, Grc, Rin, Rout, PCout, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic Yin, Zin, Zlowout, Zhighout, LOin, HIin;
  logic [12:0] alu_sel;
  logic        busy, halted;
  logic [1:0]  fault;
  logic [15:0] retired;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .mem_ready(mem_ready),
`ifdef ALU_SEQ_STEP_EN
    .step(step),
`endif
    .ir(ir), .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
    .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .Read(Read), .MDRin(MDRin),
    .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin), .alu_sel(alu_sel),
    .busy(busy), .halted(halted), .fault(fault), .retired(retired)
  );

  localparam logic [30:0] GRA = 31'd1 << 30, GRB = 31'd1 << 29, GRC = 31'd1 << 28;
  localparam logic [30:0] RIN = 31'd1 << 27, ROUT = 31'd1 << 26, PCOUT = 31'd1 << 25;
  localparam logic [30:0] INCPC = 31'd1 << 24, MARIN = 31'd1 << 23, READ = 31'd1 << 22;
  localparam logic [30:0] MDRIN = 31'd1 << 21, MDROUT = 31'd1 << 20, IRIN = 31'd1 << 19;
  localparam logic [30:0] YIN = 31'd1 << 18, ZIN = 31'd1 << 17, ZLOW = 31'd1 << 16;
  localparam logic [30:0] ZHIGH = 31'd1 << 15, LOIN = 31'd1 << 14, HIIN = 31'd1 << 13;

  localparam int K_BIN = 0, K_MD = 1, K_UN = 2, K_HALT = 3, K_ILL = 4;

  typedef struct packed {
    logic [30:0] strb;
    logic        busy;
    logic        halted;
    logic [1:0]  fault;
    logic [15:0] retired;
    logic        ready;
    logic [31:0] ir_val;
  } item_t;

  item_t       sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_ret;

  wire [30:0] strb_obs = {Gra, Grb, Grc, Rin, Rout, PCout, IncPC, MARin, Read, MDRin,
                          MDRout, IRin, Yin, Zin, Zlowout, Zhighout, LOin, HIin, alu_sel};
  wire [19:0] stat_obs = {busy, halted, fault, retired};

  task automatic push(input logic [30:0] s, input logic b, input logic h,
                      input logic [1:0] f, input logic rdy, input logic [31:0] irv);
    item_t it;
    it.strb = s; it.busy = b; it.halted = h; it.fault = f;
    it.retired = exp_ret; it.ready = rdy; it.ir_val = irv;
    sb.push_back(it);
  endtask

  task automatic push_instr(input logic [31:0] irv, input int kind,
                            input logic [12:0] alu, input int stall);
    logic [30:0] a;
    a = {18'd0, alu};
    push(PCOUT | MARIN | INCPC, 1, 0, 2'b00, 1, irv);
    for (int i = 0; i < stall; i++) push(READ | MDRIN, 1, 0, 2'b00, 0, irv);
    push(READ | MDRIN, 1, 0, 2'b00, 1, irv);
    push(MDROUT | IRIN, 1, 0, 2'b00, 1, irv);
    case (kind)
      K_BIN: begin
        push(GRB | ROUT | YIN, 1, 0, 2'b00, 1, irv);
        push(GRC | ROUT | ZIN | a, 1, 0, 2'b00, 1, irv);
        push(ZLOW | GRA | RIN, 1, 0, 2'b00, 1, irv);
        exp_ret = exp_ret + 16'd1;
      end
      K_MD: begin
        push(GRA | ROUT | YIN, 1, 0, 2'b00, 1, irv);
        push(GRB | ROUT | ZIN | a, 1, 0, 2'b00, 1, irv);
        push(ZLOW | LOIN, 1, 0, 2'b00, 1, irv);
        push(ZHIGH | HIIN, 1, 0, 2'b00, 1, irv);
        exp_ret = exp_ret + 16'd1;
      end
      K_UN: begin
        push(GRB | ROUT | ZIN | a, 1, 0, 2'b00, 1, irv);
        push(ZLOW | GRA | RIN, 1, 0, 2'b00, 1, irv);
        exp_ret = exp_ret + 16'd1;
      end
      K_HALT: begin
        push('0, 1, 0, 2'b00, 1, irv);
        exp_ret = exp_ret + 16'd1;
        push('0, 0, 1, 2'b00, 1, irv);
      end
      default: begin
        push('0, 1, 0, 2'b00, 1, irv);
        push('0, 0, 1, 2'b01, 1, irv);
      end
    endcase
  endtask

  // Called at a negedge; applies each item's inputs, compares, then moves to the next negedge.
  task automatic run_queue(input int max_n, input string name);
    item_t it;
    int    cyc;
    cyc = 0;
    while (sb.size() > 0 && (max_n < 0 || cyc < max_n)) begin
      it = sb.pop_front();
      ir = it.ir_val;
      mem_ready = it.ready;
      #1;
      n_checks++;
      if (strb_obs !== it.strb) begin
        n_fail++;
        $display("FAIL %s strobes cycle %0d: got %h expected %h", name, cyc, strb_obs, it.strb);
      end
      n_checks++;
      if (stat_obs !== {it.busy, it.halted, it.fault, it.retired}) begin
        n_fail++;
        $display("FAIL %s status cycle %0d: got busy=%b halted=%b fault=%b retired=%0d expected busy=%b halted=%b fault=%b retired=%0d",
                 name, cyc, busy, halted, fault, retired, it.busy, it.halted, it.fault, it.retired);
      end
      cyc++;
      @(negedge clk);
    end
    $display("%s: %0d cycles checked", name, cyc);
  endtask

  task automatic do_reset();
    reset = 1'b0; start = 1'b0; mem_ready = 1'b0; ir = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    exp_ret = '0;
    sb.delete();
  endtask

  task automatic begin_run(input logic [31:0] irv);
    start = 1'b1;
    push('0, 0, 0, 2'b00, 1, irv);
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b1; mem_ready = 1'b1; ir = 32'h9280_0000;
    @(negedge clk);
    n_checks++;
    if ({strb_obs, stat_obs} !== 51'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got strobes=%h status=%h expected all 0", strb_obs, stat_obs);
    end
    reset = 1'b1; start = 1'b0; exp_ret = '0;
    push('0, 0, 0, 2'b00, 1, 32'h9280_0000);
    push('0, 0, 0, 2'b00, 1, 32'h9280_0000);
    push('0, 0, 0, 2'b00, 1, 32'h9280_0000);
    run_queue(-1, "test_reset");
  endtask

  task automatic test_unary();
    do_reset();
    begin_run(32'h9280_0000);
    push_instr(32'h9280_0000, K_UN, 13'h0001, 0);
    push_instr(32'h8880_0000, K_UN, 13'h0002, 0);
    push(PCOUT | MARIN | INCPC, 1, 0, 2'b00, 1, 32'h8880_0000);
    run_queue(-1, "test_unary");
  endtask

  task automatic test_back_to_back();
    logic [4:0]  ops  [9] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                              5'b01000, 5'b01001, 5'b01010, 5'b01011};
    logic [12:0] sels [9] = '{13'h0400, 13'h0200, 13'h1000, 13'h0800, 13'h0008,
                              13'h0004, 13'h0040, 13'h0020, 13'h0010};
    do_reset();
    begin_run(32'h18B9_8000);
    push_instr(32'h18B9_8000, K_BIN, 13'h0400, 0);
    for (int i = 0; i < 9; i++)
      push_instr({ops[i], 27'h0123456}, K_BIN, sels[i], 0);
    push(PCOUT | MARIN | INCPC, 1, 0, 2'b00, 1, 32'h18B9_8000);
    run_queue(-1, "test_back_to_back");
  endtask

  task automatic test_muldiv();
    do_reset();
    begin_run(32'h7998_0000);
    push_instr(32'h7998_0000, K_MD, 13'h0100, 0);
    push_instr(32'h8119_0000, K_MD, 13'h0080, 0);
    push_instr(32'h18B9_8000, K_BIN, 13'h0400, 0);
    push(PCOUT | MARIN | INCPC, 1, 0, 2'b00, 1, 32'h18B9_8000);
    run_queue(-1, "test_muldiv");
  endtask

  task automatic test_mem_stall();
    do_reset();
    begin_run(32'h9280_0000);
    push_instr(32'h9280_0000, K_UN, 13'h0001, 4);
    push_instr(32'h18B9_8000, K_BIN, 13'h0400, 14);
    push(PCOUT | MARIN | INCPC, 1, 0, 2'b00, 1, 32'h18B9_8000);
    run_queue(-1, "test_mem_stall");
  endtask

  task automatic test_timeout();
    do_reset();
    begin_run(32'h9280_0000);
    push(PCOUT | MARIN | INCPC, 1, 0, 2'b00, 1, 32'h9280_0000);
    for (int i = 0; i < 15; i++) push(READ | MDRIN, 1, 0, 2'b00, 0, 32'h9280_0000);
    for (int i = 0; i < 3; i++) push('0, 0, 1, 2'b10, 1, 32'h9280_0000);
    run_queue(-1, "test_timeout");
  endtask

  task automatic test_illegal();
    logic [31:0] bad [3] = '{32'hF800_0000, 32'h0000_0000, 32'h6000_0000};
    for (int i = 0; i < 3; i++) begin
      do_reset();
      begin_run(32'h18B9_8000);
      push_instr(32'h18B9_8000, K_BIN, 13'h0400, 0);
      push_instr(bad[i], K_ILL, 13'h0000, 0);
      push('0, 0, 1, 2'b01, 1, bad[i]);
      run_queue(-1, "test_illegal");
    end
  endtask

  task automatic test_halt();
    do_reset();
    begin_run(32'h18B9_8000);
    push_instr(32'h18B9_8000, K_BIN, 13'h0400, 0);
    push_instr(32'hD800_0000, K_HALT, 13'h0000, 0);
    push('0, 0, 1, 2'b00, 1, 32'h18B9_8000);
    push('0, 0, 1, 2'b00, 1, 32'h18B9_8000);
    run_queue(-1, "test_halt");
  endtask

  task automatic test_reset_mid();
    do_reset();
    begin_run(32'h9280_0000);
    push_instr(32'h9280_0000, K_UN, 13'h0001, 0);
    push_instr(32'h18B9_8000, K_BIN, 13'h0400, 0);
    run_queue(10, "test_reset_mid_pre");
    ir = 32'h18B9_8000;
    #1;
    n_checks++;
    if (strb_obs !== (GRC | ROUT | ZIN | 31'h0400) || retired !== 16'd1) begin
      n_fail++;
      $display("FAIL reset_mid_t4: got strobes=%h retired=%0d expected %h retired=1",
               strb_obs, retired, GRC | ROUT | ZIN | 31'h0400);
    end
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({strb_obs, stat_obs} !== 51'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got strobes=%h status=%h expected all 0", strb_obs, stat_obs);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({strb_obs, stat_obs} !== 51'd0) begin
      n_fail++;
      $display("FAIL reset_mid_held: got strobes=%h status=%h expected all 0", strb_obs, stat_obs);
    end
    @(negedge clk);
    reset = 1'b1; start = 1'b0; exp_ret = '0; sb.delete();
    push('0, 0, 0, 2'b00, 1, 32'h18B9_8000);
    push('0, 0, 0, 2'b00, 1, 32'h18B9_8000);
    run_queue(-1, "test_reset_mid_post");
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mem_ready = 1'b0; ir = '0; exp_ret = '0;
    test_reset();
    test_unary();
    test_back_to_back();
    test_muldiv();
    test_mem_stall();
    test_timeout();
    test_illegal();
    test_halt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
Hardwired control unit that sequences the existing 32-bit datapath through fetch and execute of register-format ALU instructions. It drives the one-hot bus-source, register-load and ALU-select strobes that test benches currently toggle by hand. It sits beside the datapath, reads the IR contents back, and handshakes with memory through a single ready line. It also counts retired instructions and stops on halt or illegal opcodes.

Parameters:
CNT_W, 16, width of retired-instruction counter
T1_TIMEOUT, 15, max cycles waiting for mem_ready in T1 before fault; 0 disables timeout

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  level; FSM leaves IDLE while high
mem_ready  in  1  memory read data valid on MDR input this cycle
ir  in  32  current IR register contents from datapath
Gra, Grb, Grc  out  1 each  select IR Ra[26:23] / Rb[22:19] / Rc[18:15] field for register decode
Rin, Rout  out  1 each  load / drive selected general register
PCout, IncPC, MARin, Read, MDRin, MDRout, IRin  out  1 each  fetch strobes
Yin, Zin, Zlowout, Zhighout, LOin, HIin  out  1 each  execute strobes
alu_sel  out  13  one-hot {AND,OR,ADD,SUB,MUL,DIV,SHR,SHRA,SHL,ROR,ROL,NEG,NOT}; MSB=AND
busy  out  1  high in any state except IDLE/HALT
halted  out  1  high in HALT
fault  out  2  00 none, 01 illegal opcode, 10 memory timeout; sticky until reset
retired  out  CNT_W  count of completed instructions

Behaviour:
- Reset (reset=0, async): state=IDLE, every output 0, retired=0, fault=00, timeout counter=0.
- Strobes are Moore outputs decoded from the registered state. A strobe is high for exactly the cycles the FSM is in the listed state. The datapath captures on the posedge that ends the state.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT (4-bit encoding).
- IDLE: start=1 -> T0, else stay.
- T0: PCout, MARin, IncPC -> T1.
- T1: Read, MDRin. Stay while mem_ready=0; go to T2 on mem_ready=1.
  - With T1_TIMEOUT>0, if the wait counter reaches T1_TIMEOUT: fault=10, go to HALT.
  - The wait counter clears on T1 entry.
- T2: MDRout, IRin -> T3.
- From T3, decode op = ir[31:27], sampled in T3 and held in an internal register through T6.
- Opcodes: 00011 ADD, 00100 SUB, 00101 AND, 00110 OR, 00111 ROR, 01000 ROL, 01001 SHR, 01010 SHRA, 01011 SHL, 01111 MUL, 10000 DIV, 10001 NEG, 10010 NOT, 11011 HALT. Any other opcode is illegal.
- Binary ops (ADD..SHL):
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, alu_sel bit, Zin.
  - T5: Zlowout, Gra, Rin.
  - Then back to T0.
- MUL/DIV:
  - T3: Gra, Rout, Yin.
  - T4: Grb, Rout, alu_sel, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhighout, HIin.
  - Then T0.
- Unary NEG/NOT:
  - T3: Grb, Rout, alu_sel, Zin.
  - T4: Zlowout, Gra, Rin.
  - Then T0.
- HALT opcode: in T3, no strobes, go to HALT and increment retired.
- Illegal opcode: in T3, fault=01, go to HALT without incrementing retired.
- retired increments by 1 on the final execute cycle's edge (T5 binary, T6 MUL/DIV, T4 unary, T3 HALT). It wraps at 2^CNT_W-1 -> 0.
- start is sampled only in IDLE. Deasserting start mid-instruction has no effect; the next instruction still fetches (free-running until HALT).
- HALT: halted=1, busy=0. Exits only via reset.
- alu_sel is high only in the Zin cycle, so at most one bit of alu_sel is ever set.
- Never more than one bus driver (PCout, MDRout, Rout, Zlowout, Zhighout) high in the same cycle.
- reset asserted mid-instruction aborts immediately. No partial strobes persist after reset.

Optional Feature:
ALU_SEQ_STEP_EN: adds input port step (1 bit).
- Defined: in T0, the FSM stays in T0 (strobes low) until a step=1 cycle, so execution advances one instruction per step pulse.
- Undefined: no step port; T0 always proceeds after one cycle.

Test Plan:
- Reset then start=1, mem_ready=1, ir=0x92800000 (NOT R5,R0) -> T0,T1,T2,T3,T4. T3 shows Grb, Rout, NOT bit (alu_sel=13'h0001), Zin. T4 shows Zlowout, Gra, Rin. retired=1, back in T0.
- ir=0x18B98000 (ADD R1,R7,R3) -> T3 Grb/Rout/Yin, T4 Grc/Rout/ADD/Zin, T5 Zlowout/Gra/Rin. Instruction takes 6 cycles.
- ir=0x79980000 (MUL, Ra=R3, Rb=R3) -> T5 LOin with Zlowout, T6 HIin with Zhighout. Total 7 cycles.
- mem_ready held 0 for 4 cycles in T1 -> Read and MDRin stay high 5 cycles. With T1_TIMEOUT=3, stall 3 cycles -> fault=10, halted=1.
- ir=0xF8000000 (opcode 11111) -> fault=01, halted=1, retired unchanged. ir=0xD8000000 (HALT) -> halted=1, fault=00, retired+1.
- Assert reset low during T4 of ADD -> all strobes 0 asynchronously, state IDLE, retired=0.
